mips_cpu_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the MIPS CPU. Sits beside the combinational decoder and issues per-cycle

---
 rtl/mips_cpu_ctrl_pkg.sv | 51 +++++
 rtl/mips_cpu_ctrl_class.sv | 57 +++++
 rtl/mips_cpu_ctrl_fsm.sv | 147 ++++++++++++++
 tb/tb_mips_cpu_ctrl_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_ctrl_pkg.sv
// Shared types for the MIPS multi-cycle control sequencer: MIPS I field
// encodings, FSM state encoding and the coarse instruction classes.
package mips_cpu_ctrl_pkg;

  // Primary opcode field instr[31:26]
  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
    OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
    OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
    OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23,
    OP_LBU     = 6'h24, OP_LHU    = 6'h25, OP_LWR   = 6'h26,
    OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SWL   = 6'h2A, OP_SW    = 6'h2B,
    OP_SWR     = 6'h2E
  } op_enum;

  // SPECIAL function field instr[5:0]
  typedef enum logic [5:0] {
    F_SLL   = 6'h00, F_SRL   = 6'h02, F_SRA   = 6'h03, F_SLLV  = 6'h04,
    F_SRLV  = 6'h06, F_SRAV  = 6'h07, F_JR    = 6'h08, F_JALR  = 6'h09,
    F_SYSCALL = 6'h0C, F_BREAK = 6'h0D,
    F_MFHI  = 6'h10, F_MTHI  = 6'h11, F_MFLO  = 6'h12, F_MTLO  = 6'h13,
    F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV   = 6'h1A, F_DIVU  = 6'h1B,
    F_ADD   = 6'h20, F_ADDU  = 6'h21, F_SUB   = 6'h22, F_SUBU  = 6'h23,
    F_AND   = 6'h24, F_OR    = 6'h25, F_XOR   = 6'h26, F_NOR   = 6'h27,
    F_SLT   = 6'h2A, F_SLTU  = 6'h2B
  } funct_enum;

  // REGIMM rt field instr[20:16]
  typedef enum logic [4:0] {
    RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11
  } rt_enum;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_MULDIV = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LINK, C_LOAD, C_STORE, C_MULDIV, C_SPCW, C_BRANCH, C_NOP
  } iclass_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mips_cpu_ctrl_class.sv
// Combinational instruction classifier: maps a MIPS I instruction word to
// the coarse class that decides which sequence the control FSM runs.
module mips_cpu_ctrl_class
  import mips_cpu_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output iclass_t     o_class
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  logic       w_unused;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  assign w_rt    = i_instr[20:16];
  // Register numbers, shamt and immediates do not affect sequencing.
  assign w_unused = ^{i_instr[25:21], i_instr[15:6]};

  // Decode opcode, then funct (SPECIAL) or rt (REGIMM); anything unlisted is a NOP.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    o_class = C_NOP;
    case (w_op)
      OP_SPECIAL: begin
        case (w_funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_MFHI, F_MFLO,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:                    o_class = C_ALU;
          F_JR:                             o_class = C_BRANCH;
          F_JALR:                           o_class = C_LINK;
          F_MTHI, F_MTLO:                   o_class = C_SPCW;
          F_MULT, F_MULTU, F_DIV, F_DIVU:   o_class = C_MULDIV;
          default:                          o_class = C_NOP;
        endcase
      end
      OP_REGIMM: begin
        case (w_rt)
          RT_BLTZ, RT_BGEZ:                 o_class = C_BRANCH;
          RT_BLTZAL, RT_BGEZAL:             o_class = C_LINK;
          default:                          o_class = C_NOP;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_class = C_BRANCH;
      OP_JAL:                                 o_class = C_LINK;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:       o_class = C_ALU;
      OP_LB, OP_LH, OP_LWL, OP_LW,
      OP_LBU, OP_LHU, OP_LWR:                 o_class = C_LOAD;
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR:    o_class = C_STORE;
      default:                                o_class = C_NOP;
    endcase
  end

endmodule

// File: rtl/mips_cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS core. Issues per-cycle strobes
// for fetch, execute, memory access, HI/LO write and PC commit; stalls on
// memory waitrequest and on the mult/div latency; halts after the delay slot
// of a jump to address 0.
module mips_cpu_ctrl_fsm
  import mips_cpu_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int MEM_TIMEOUT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        waitrequest,
  input  logic        jump_to_zero,
  output logic        active,
  output logic [2:0]  state,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_load,
  output logic        pc_en,
  output logic        reg_write,
  output logic        spc_reg_write,
  output logic        muldiv_start
);

  localparam int CNT_W = $clog2(max2(MULDIV_CYCLES, MEM_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] MULDIV_LAST  = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_halt_pend;
  logic             w_halt_pend_next;
  logic             w_retire;
  iclass_t          w_class;

  mips_cpu_ctrl_class u_class (
    .i_instr (instr),
    .o_class (w_class)
  );

  assign state = r_state;

  // State, counter and delay-slot flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state     <= S_FETCH;
      r_cnt       <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_halt_pend <= w_halt_pend_next;
    end
  end

  // Next-state, counter and strobe decode; reset forces every strobe low.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_halt_pend_next = r_halt_pend;
    w_retire         = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_load          = 1'b0;
    pc_en            = 1'b0;
    reg_write        = 1'b0;
    spc_reg_write    = 1'b0;
    muldiv_start     = 1'b0;
    active           = !reset && (r_state != S_HALT) && (r_state != S_ERROR);

    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_load      = 1'b1;
            w_state_next = S_EXEC;
          end
        end

        S_EXEC: begin
          // A jump to 0 inside the delay slot is ignored: only the first arms the halt.
          if (jump_to_zero && !r_halt_pend) w_halt_pend_next = 1'b1;
          unique case (w_class)
            C_LOAD, C_STORE: begin
              w_cnt_next   = '0;
              w_state_next = S_MEM;
            end
            C_MULDIV: begin
              muldiv_start = 1'b1;
              w_cnt_next   = MULDIV_LAST;
              w_state_next = S_MULDIV;
            end
            C_ALU, C_LINK: begin
              reg_write = 1'b1;
              w_retire  = 1'b1;
            end
            C_SPCW: begin
              spc_reg_write = 1'b1;
              w_retire      = 1'b1;
            end
            default: w_retire = 1'b1;
          endcase
        end

        S_MEM: begin
          // The IR still holds the load/store, so the class selects the strobe.
          if (w_class == C_STORE) mem_write = 1'b1;
          else                    mem_read  = 1'b1;
          if (!waitrequest) begin
            // Completion is checked first, so it wins over a timeout in the same cycle.
            reg_write = (w_class != C_STORE);
            w_retire  = 1'b1;
          end else if (MEM_TIMEOUT > 0) begin
            if (r_cnt == TIMEOUT_LAST) w_state_next = S_ERROR;
            else                       w_cnt_next   = r_cnt + 1'b1;
          end
        end

        S_MULDIV: begin
          if (r_cnt == '0) begin
            spc_reg_write = 1'b1;
            w_retire      = 1'b1;
          end else begin
            w_cnt_next = r_cnt - 1'b1;
          end
        end

        S_HALT, S_ERROR: ;

        default: w_state_next = S_ERROR;
      endcase

      // Commit the PC; the instruction after an armed jump-to-zero stops the core.
      if (w_retire) begin
        pc_en        = 1'b1;
        w_state_next = r_halt_pend ? S_HALT : S_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_ctrl_fsm.sv
// Scoreboard bench for mips_cpu_ctrl_fsm. The driver paces each instruction
// cycle by cycle from an ISA-level model and queues the expected strobe totals
// per instruction window; the monitor closes a window on retire, error entry or
// reset and compares.
module tb_mips_cpu_ctrl_fsm;
  import mips_cpu_ctrl_pkg::*;

  localparam int MD = 4;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        waitrequest;
  logic        jump_to_zero;
  logic        active;
  logic [2:0]  state;
  logic        mem_read, mem_write, ir_load, pc_en;
  logic        reg_write, spc_reg_write, muldiv_start;

  always #5 clk = ~clk;

  mips_cpu_ctrl_fsm #(.MULDIV_CYCLES(MD), .MEM_TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .waitrequest   (waitrequest),
    .jump_to_zero  (jump_to_zero),
    .active        (active),
    .state         (state),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_load       (ir_load),
    .pc_en         (pc_en),
    .reg_write     (reg_write),
    .spc_reg_write (spc_reg_write),
    .muldiv_start  (muldiv_start)
  );

  // ISA effect of an instruction, independent of any FSM detail
  typedef enum {E_NONE, E_ALU, E_HILO, E_MD, E_LOAD, E_STORE} eff_t;
  typedef struct { string name; int op; int sel; eff_t eff; } row_t;
  typedef enum {K_RETIRE, K_ERROR, K_RESET} kind_t;
  typedef struct {
    string name; kind_t kind;
    int cycles, mr, mw, rw, srw, ms, il;
    bit halt_next;
  } exp_t;

  row_t tab[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input int op, input int sel, input eff_t e);
    row_t r;
    r.name = n; r.op = op; r.sel = sel; r.eff = e;
    tab.push_back(r);
  endfunction

  function automatic int find(input string n);
    foreach (tab[i]) if (tab[i].name == n) return i;
    return 0;
  endfunction

  function automatic logic [31:0] mk_ins(input int idx);
    logic [31:0] w;
    logic [31:0] op, sel;
    w   = $urandom;
    op  = tab[idx].op;
    sel = tab[idx].sel;
    w[31:26] = op[5:0];
    if (tab[idx].op == 0) w[5:0]   = sel[5:0];
    if (tab[idx].op == 1) w[20:16] = sel[4:0];
    return w;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] ins, input logic wr, input logic j0);
    instr = ins; waitrequest = wr; jump_to_zero = j0; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cyc, input int mr, input int mw, input int ms, input int il);
    exp_t e;
    e.name = "reset"; e.kind = K_RESET; e.cycles = cyc;
    e.mr = mr; e.mw = mw; e.rw = 0; e.srw = 0; e.ms = ms; e.il = il; e.halt_next = 0;
    sb.push_back(e);
    reset = 1'b1; instr = $urandom; waitrequest = 1'($urandom); jump_to_zero = 1'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    armed = 0;
  endtask

  // One instruction: f fetch stalls, m memory stalls, j0 = taken jump to 0.
  task automatic run_instr(input int idx, input int f, input int m, input bit j0, output bit halted);
    exp_t        e;
    logic [31:0] ins;
    bit          jz;
    ins = mk_ins(idx);
    jz  = j0 && (tab[idx].eff inside {E_NONE, E_ALU});
    e.name = tab[idx].name; e.kind = K_RETIRE;
    e.cycles = f + 2; e.mr = f + 1; e.mw = 0; e.rw = 0; e.srw = 0; e.ms = 0; e.il = 1;
    case (tab[idx].eff)
      E_ALU:   e.rw = 1;
      E_HILO:  e.srw = 1;
      E_MD:    begin e.srw = 1; e.ms = 1; e.cycles += MD; end
      E_LOAD:  begin e.rw = 1; e.mr += m + 1; e.cycles += m + 1; end
      E_STORE: begin e.mw = m + 1; e.cycles += m + 1; end
      default: ;
    endcase
    e.halt_next = armed;
    halted = armed;
    if (jz && !armed) armed = 1;
    sb.push_back(e);
    repeat (f) step(ins, 1'b1, 1'b0);
    step(ins, 1'b0, 1'b0);
    step(ins, 1'($urandom), jz);
    if (tab[idx].eff inside {E_LOAD, E_STORE}) begin
      repeat (m) step(ins, 1'b1, 1'b0);
      step(ins, 1'b0, 1'b0);
    end
    if (tab[idx].eff == E_MD) repeat (MD) step(ins, 1'($urandom), 1'b0);
  endtask

  task automatic halt_and_reset(input int h);
    repeat (h) step($urandom, 1'($urandom), 1'($urandom));
    do_reset(h + 1, 0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  int     acc_cyc = 0, acc_mr = 0, acc_mw = 0, acc_rw = 0, acc_srw = 0, acc_ms = 0, acc_il = 0;
  bit     pend_next = 0;
  bit     err_seen  = 0;
  state_t exp_st;

  always @(negedge clk) begin
    kind_t k;
    bit    ev;
    exp_t  e;
    acc_cyc++;
    acc_mr  += int'(mem_read);
    acc_mw  += int'(mem_write);
    acc_rw  += int'(reg_write);
    acc_srw += int'(spc_reg_write);
    acc_ms  += int'(muldiv_start);
    acc_il  += int'(ir_load);

    if (pend_next) begin
      check("next_state", state, exp_st);
      check("next_active", active, (exp_st == S_FETCH));
      pend_next = 0;
    end
    check("write_exclusive", (int'(reg_write) + int'(spc_reg_write) + int'(mem_write)) <= 1, 1);
    check("rd_wr_exclusive", mem_read && mem_write, 0);
    if (state == S_HALT || state == S_ERROR)
      check("stopped_quiet", {active, mem_read, mem_write, ir_load, pc_en,
                              reg_write, spc_reg_write, muldiv_start}, 0);

    ev = 1; k = K_RETIRE;
    if (reset) begin k = K_RESET; err_seen = 0; end
    else if (pc_en) k = K_RETIRE;
    else if (state == S_ERROR && !err_seen) begin k = K_ERROR; err_seen = 1; end
    else ev = 0;

    if (ev) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: kind %0d with empty scoreboard", k);
      end else begin
        e = sb.pop_front();
        check({e.name, " kind"}, k, e.kind);
        check({e.name, " cycles"}, acc_cyc, e.cycles);
        check({e.name, " mem_read"}, acc_mr, e.mr);
        check({e.name, " mem_write"}, acc_mw, e.mw);
        check({e.name, " reg_write"}, acc_rw, e.rw);
        check({e.name, " spc_reg_write"}, acc_srw, e.srw);
        check({e.name, " muldiv_start"}, acc_ms, e.ms);
        check({e.name, " ir_load"}, acc_il, e.il);
        if (e.kind == K_RETIRE) begin
          check({e.name, " reg_write@retire"}, reg_write, e.rw);
          check({e.name, " spc_reg_write@retire"}, spc_reg_write, e.srw);
        end
        if (e.kind == K_RESET) check("active_in_reset", active, 0);
        exp_st    = e.halt_next ? S_HALT : ((e.kind == K_ERROR) ? S_ERROR : S_FETCH);
        pend_next = 1;
      end
      acc_cyc = 0; acc_mr = 0; acc_mw = 0; acc_rw = 0; acc_srw = 0; acc_ms = 0; acc_il = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          h;
    logic [31:0] ins;
    exp_t        e;

    add("ADDU", 0, 'h21, E_ALU);  add("SUB", 0, 'h22, E_ALU);   add("SLL", 0, 'h00, E_ALU);
    add("SLT", 0, 'h2A, E_ALU);   add("NOR", 0, 'h27, E_ALU);   add("MFHI", 0, 'h10, E_ALU);
    add("MFLO", 0, 'h12, E_ALU);  add("JR", 0, 'h08, E_NONE);   add("JALR", 0, 'h09, E_ALU);
    add("MTHI", 0, 'h11, E_HILO); add("MTLO", 0, 'h13, E_HILO);
    add("MULT", 0, 'h18, E_MD);   add("MULTU", 0, 'h19, E_MD);  add("DIV", 0, 'h1A, E_MD);
    add("DIVU", 0, 'h1B, E_MD);   add("SPC?3F", 0, 'h3F, E_NONE); add("SPC?01", 0, 'h01, E_NONE);
    add("BLTZ", 1, 'h00, E_NONE); add("BGEZAL", 1, 'h11, E_ALU); add("BLTZAL", 1, 'h10, E_ALU);
    add("RIMM?05", 1, 'h05, E_NONE);
    add("J", 2, 0, E_NONE);       add("JAL", 3, 0, E_ALU);      add("BEQ", 4, 0, E_NONE);
    add("BGTZ", 7, 0, E_NONE);    add("ADDIU", 9, 0, E_ALU);    add("LUI", 'h0F, 0, E_ALU);
    add("ORI", 'h0D, 0, E_ALU);   add("LB", 'h20, 0, E_LOAD);   add("LW", 'h23, 0, E_LOAD);
    add("LHU", 'h25, 0, E_LOAD);  add("LWR", 'h26, 0, E_LOAD);  add("SB", 'h28, 0, E_STORE);
    add("SH", 'h29, 0, E_STORE);  add("SW", 'h2B, 0, E_STORE);  add("OP?3F", 'h3F, 0, E_NONE);
    add("OP?2C", 'h2C, 0, E_NONE); add("OP?13", 'h13, 0, E_NONE);

    reset = 1'b1; instr = '0; waitrequest = 1'b0; jump_to_zero = 1'b0;
    @(posedge clk); #1;
    do_reset(1, 0, 0, 0, 0);

    // Basic ALU, load with 3 stalls, MULT over the full latency
    run_instr(find("ADDU"), 0, 0, 0, h);
    run_instr(find("LW"), 0, 3, 0, h);
    run_instr(find("MULT"), 0, 0, 0, h);
    // Store completing on the cycle the stall count would reach the limit
    run_instr(find("SW"), 1, TO - 1, 0, h);

    // Jump to 0 followed by its delay slot, then halt
    run_instr(find("JR"), 0, 0, 1, h);
    run_instr(find("ADDIU"), 0, 0, 0, h);
    halt_and_reset(3);

    // Second jump to 0 inside the delay slot is ignored
    run_instr(find("JR"), 0, 0, 1, h);
    run_instr(find("J"), 0, 0, 1, h);
    halt_and_reset(2);

    // Store with waitrequest stuck high: error after TO stall cycles
    ins = mk_ins(find("SW"));
    e.name = "SW_timeout"; e.kind = K_ERROR; e.cycles = 2 + TO + 1;
    e.mr = 1; e.mw = TO; e.rw = 0; e.srw = 0; e.ms = 0; e.il = 1; e.halt_next = 0;
    sb.push_back(e);
    step(ins, 1'b0, 1'b0);
    repeat (1 + TO + 1 + 3) step(ins, 1'b1, 1'b0);
    do_reset(4, 0, 0, 0, 0);

    // Reset in the second MULDIV cycle: no HI/LO write, restart at FETCH
    ins = mk_ins(find("MULT"));
    step(ins, 1'b0, 1'b0);
    step(ins, 1'b0, 1'b0);
    step(ins, 1'b0, 1'b0);
    do_reset(4, 1, 0, 1, 1);

    // Randomised instruction stream
    for (int n = 0; n < 200; n++) begin
      run_instr($urandom_range(0, tab.size() - 1), $urandom_range(0, 3),
                $urandom_range(0, TO - 1), ($urandom_range(0, 7) == 0), h);
      if (h) halt_and_reset($urandom_range(1, 4));
    end

    repeat (4) step('0, 1'b1, 1'b0);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
